mips_multicycle_control: RTL

Multi-cycle main control FSM for the MIPS datapath. It decodes the 6-bit opcode of the instruction register. Each instruction is sequenced through fetch, decode, execute, memory and writeback steps, driving every datapath select and write-enable, including the 2-bit `ula_operation` consumed by `ula_control`. It stalls on a memory-ready handshake and flags illegal opcodes and memory timeouts.

---
 rtl/mips_multicycle_control.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives every datapath select and enable, and flags illegal opcodes and memory timeouts.
module mips_multicycle_control #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       ula_src_a,
    output logic [1:0] ula_src_b,
    output logic [1:0] ula_operation,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             r_illegal;
    logic             r_timeout;
    logic             w_wait_state;
    logic             w_expire;
    logic             w_bad_op;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                          (r_state == S_MEM_WRITE);
    assign w_expire     = w_wait_state && !mem_ready && (r_count == LIMIT);
    assign w_bad_op     = !((opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                            (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J));

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   w_next = S_R_WB;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            default:     w_next = S_FETCH;
        endcase
    end

    // The wait counter only runs while a wait state is stalled; any progress clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_expire) begin
            r_state   <= S_FETCH;
            r_count   <= '0;
            r_timeout <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_wait_state && !mem_ready)
                r_count <= r_count + CNT_W'(1);
            else
                r_count <= '0;
            if (r_state == S_DECODE && w_bad_op)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        ula_src_a     = 1'b0;
        ula_src_b     = 2'b00;
        ula_operation = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ula_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:    ula_src_b = 2'b11;
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ula_src_a = 1'b1;
                ula_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ula_src_a     = 1'b1;
                ula_operation = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ula_src_a     = 1'b1;
                ula_operation = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_WB:   reg_write = 1'b1;
            default: ;
        endcase
        // An aborting wait cycle must not commit anything; reset kills every strobe.
        if (w_expire) begin
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
        end
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
        end
    end

    assign state       = r_state;
    assign illegal_op  = r_illegal;
    assign mem_timeout = r_timeout;

endmodule
